// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB digit first,
// producing a WIDTH-bit result with carry-out and signed overflow after N = WIDTH/DIGIT cycles.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum, w_sum_next;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_a_d, w_b_d;
  logic [DIGIT:0]   w_dsum;
  logic             w_last, w_msb_cin, w_accept;

  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_accept = start && (r_state != RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Constant-index mux over digits keeps the part-selects static.
  always_comb begin
    w_a_d      = '0;
    w_b_d      = '0;
    w_sum_next = r_sum;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_d = r_a[k*DIGIT +: DIGIT];
        w_b_d = r_b[k*DIGIT +: DIGIT];
      end
    end
    w_dsum    = {1'b0, w_a_d} + {1'b0, w_b_d} + {{DIGIT{1'b0}}, r_carry};
    w_msb_cin = w_a_d[DIGIT-1] ^ w_b_d[DIGIT-1] ^ w_dsum[DIGIT-1];
    for (int unsigned k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) w_sum_next[k*DIGIT +: DIGIT] = w_dsum[DIGIT-1:0];
    end
  end

  // Subtraction is folded in at capture time: B and carry-in are inverted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_dsum[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_msb_cin ^ w_dsum[DIGIT];
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: stimulus pushes model results (with expected done cycle),
// per-DUT monitors pop and compare whenever done is seen.
module tb_digit_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        sub_i = 1'b0, cin_i = 1'b0;
  logic [15:0] a_i = '0, b_i = '0;

  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] sum2;

  int   n_cmp = 0, n_bad = 0, cyc = 0, dones1 = 0;
  exp_t q1[$], q2[$];

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Integer arithmetic reference: unsigned result for sum/cout, signed for ovf.
  function automatic exp_t model(input logic [15:0] a, b, input logic sub, cin, input int dcyc);
    exp_t m;
    int ua, ub, sa, sb, ci, r, sr;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); ci = cin;
    if (!sub) begin r = ua + ub + ci; sr = sa + sb + ci; end
    else      begin r = ua - ub - ci; sr = sa - sb - ci; end
    m.sum  = r[15:0];
    m.cout = sub ? (r >= 0) : (r > 65535);
    m.ovf  = (sr > 32767) || (sr < -32768);
    m.cyc  = dcyc;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done1) begin
      exp_t e;
      dones1++;
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d4_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("d4_sum", sum1, e.sum);
        chk("d4_cout", cout1, e.cout);
        chk("d4_ovf", ovf1, e.ovf);
        chk("d4_done_cycle", cyc, e.cyc);
        chk("d4_busy_in_done", busy1, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      exp_t e;
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d16_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        e = q2.pop_front();
        chk("d16_sum", sum2, e.sum);
        chk("d16_cout", cout2, e.cout);
        chk("d16_ovf", ovf2, e.ovf);
        chk("d16_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (E0).
  task automatic op(input bit which, input logic [15:0] aa, bb, input logic ss, cc, input bit push);
    a_i = aa; b_i = bb; sub_i = ss; cin_i = cc;
    if (which) begin
      start2 = 1'b1;
      if (push) q2.push_back(model(aa, bb, ss, cc, cyc + 2));
    end else begin
      start1 = 1'b1;
      if (push) q1.push_back(model(aa, bb, ss, cc, cyc + 5));
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   c, d;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_sum", sum1, 0);
    chk("rst_cout", cout1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_busy_d16", busy2, 0);

    // Start on the first edge after reset release, add with wrap.
    rst = 1'b0;
    op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    repeat (6) @(negedge clk);
    op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    repeat (6) @(negedge clk);
    op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1);
    repeat (6) @(negedge clk);
    op(0, 16'h0003, 16'h0005, 1'b1, 1'b0, 1);
    repeat (6) @(negedge clk);

    // Start while busy must be ignored; partial sum has only digit 0 written.
    e = model(16'h1234, 16'h0F0F, 1'b0, 1'b1, 0);
    op(0, 16'h1234, 16'h0F0F, 1'b0, 1'b1, 1);
    chk("run_busy", busy1, 1);
    chk("run_done", done1, 0);
    chk("run_cout", cout1, 0);
    chk("run_ovf", ovf1, 0);
    a_i = 16'hFFFF; b_i = 16'hFFFF; sub_i = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("partial_hi_zero", sum1[15:4], 0);
    chk("partial_digit0", sum1[3:0], e.sum[3:0]);
    repeat (5) @(negedge clk);

    // Start held high: second done exactly 5 cycles after the first.
    c = cyc;
    a_i = 16'h00FF; b_i = 16'h0F01; sub_i = 1'b0; cin_i = 1'b0; start1 = 1'b1;
    q1.push_back(model(16'h00FF, 16'h0F01, 1'b0, 1'b0, c + 5));
    q1.push_back(model(16'hA000, 16'h6001, 1'b1, 1'b1, c + 10));
    @(negedge clk);
    a_i = 16'hA000; b_i = 16'h6001; sub_i = 1'b1; cin_i = 1'b1;
    repeat (5) @(negedge clk);
    start1 = 1'b0;
    repeat (6) @(negedge clk);

    // Reset asserted mid-operation aborts it.
    op(0, 16'hABCD, 16'h1111, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_sum", sum1, 0);
    d = dones1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", dones1, d);

    // Degenerate single-digit configuration.
    op(1, 16'h1234, 16'h4321, 1'b0, 1'b1, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Random operations with gaps that include back-to-back restarts from DONE.
    for (int i = 0; i < 40; i++) begin
      op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
      repeat ($urandom_range(4, 7)) @(negedge clk);
    end
    repeat (8) @(negedge clk);

    chk("d4_queue_drained", q1.size(), 0);
    chk("d16_queue_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
